// File: rtl/ifid_pkg.sv
// Shared types and constants for the fetch-to-decode skid boundary.
// The idle beat (RESET_PC / NOP) is what decode sees whenever nothing valid is held.
package ifid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_beat_t;

  localparam logic [31:0] IFID_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] IFID_RESET_PC = 32'h8000_0000;

  function automatic ifid_beat_t ifid_make_beat(input logic [31:0] pc,
                                                input logic [31:0] inst);
    ifid_beat_t b;
    b.pc   = pc;
    b.inst = inst;
    return b;
  endfunction

endpackage

// File: rtl/ifid_beat_reg.sv
// One {pc, inst} storage entry: async reset and synchronous clear both load the idle beat,
// clear wins over load so a flush can never be overridden by a same-cycle capture.
module ifid_beat_reg
  import ifid_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFID_RESET_PC,
  parameter logic [31:0] NOP_INST = IFID_NOP_INST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       load_i,
  input  ifid_beat_t d_i,
  output ifid_beat_t q_o
);

  ifid_beat_t beat_q;
  ifid_beat_t beat_d;

  always_comb begin
    beat_d = beat_q;
    if (clr_i) begin
      beat_d = ifid_make_beat(RESET_PC, NOP_INST);
    end else if (load_i) begin
      beat_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= ifid_make_beat(RESET_PC, NOP_INST);
    end else begin
      beat_q <= beat_d;
    end
  end

  assign q_o = beat_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// Fetch-to-decode pipeline boundary: 2-entry skid buffer (OUT drives decode, SKID absorbs
// one overflow beat) so fetch's ready is a flop and never sees decode's stall combinationally.
module if_id_skid_reg
  import ifid_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFID_RESET_PC,
  parameter logic [31:0] NOP_INST = IFID_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IFU_o_pc,
  input  logic [31:0] IFU_o_inst,
  input  logic        IFU_o_valid,
  output logic        IFU_i_ready,
  output logic [31:0] IDU_i_pc,
  output logic [31:0] IDU_i_inst,
  output logic        IDU_i_commit,
  input  logic        IDU_stall,
  input  logic        EXU_o_flush
);

  ifid_state_t state_q, state_d;
  logic        ready_q, ready_d;

  logic        in_fire;
  logic        out_fire;
  logic        out_load;
  logic        out_from_skid;
  logic        skid_load;
  ifid_beat_t  in_beat;
  ifid_beat_t  out_d;
  ifid_beat_t  out_q;
  ifid_beat_t  skid_q;

  assign in_beat  = ifid_make_beat(IFU_o_pc, IFU_o_inst);
  assign in_fire  = IFU_o_valid & ready_q;
  assign out_fire = (state_q != EMPTY) & ~IDU_stall;

  // Occupancy transitions; flush overrides everything, including this cycle's in_fire.
  always_comb begin
    state_d       = state_q;
    out_load      = 1'b0;
    out_from_skid = 1'b0;
    skid_load     = 1'b0;
    if (!EXU_o_flush) begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d  = ONE;
            out_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            out_load = 1'b1;
          end else if (in_fire) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d       = ONE;
            out_load      = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = EMPTY;
    end
  end

  assign ready_d = (state_d != TWO);
  assign out_d   = out_from_skid ? skid_q : in_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  ifid_beat_reg #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (EXU_o_flush),
    .load_i (out_load),
    .d_i    (out_d),
    .q_o    (out_q)
  );

  ifid_beat_reg #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) u_skid_reg (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (EXU_o_flush),
    .load_i (skid_load),
    .d_i    (in_beat),
    .q_o    (skid_q)
  );

  // OUT may still hold a consumed beat after ONE->EMPTY, so the idle beat is muxed in explicitly.
  assign IFU_i_ready  = ready_q;
  assign IDU_i_commit = (state_q != EMPTY);
  assign IDU_i_pc     = IDU_i_commit ? out_q.pc   : RESET_PC;
  assign IDU_i_inst   = IDU_i_commit ? out_q.inst : NOP_INST;

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

Registered fetch-to-decode pipeline boundary: a 2-entry skid buffer between the fetch unit and the decode stage. It accepts one `{pc, inst}` beat per cycle from fetch under a valid/ready handshake. It holds the beat on the decode-side outputs until decode consumes it. It absorbs one extra beat when decode stalls, so fetch's ready never depends combinationally on the stall. It also drops all buffered instructions on a control-flow flush from execute.

## Interface
- `RESET_PC`, default `32'h8000_0000`: value driven on `IDU_i_pc` while empty/after reset.
- `NOP_INST`, default `32'h0000_0013` (addi x0,x0,0): value driven on `IDU_i_inst` while empty/after reset.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `IFU_o_pc` in 32: fetched PC.
- `IFU_o_inst` in 32: fetched instruction.
- `IFU_o_valid` in 1: fetch beat valid.
- `IFU_i_ready` out 1: buffer can accept a beat this cycle (registered).
- `IDU_i_pc` out 32: PC presented to decode.
- `IDU_i_inst` out 32: instruction presented to decode.
- `IDU_i_commit` out 1: presented instruction is valid (decode's commit input).
- `IDU_stall` in 1: decode/hazard unit cannot consume the presented instruction this cycle.
- `EXU_o_flush` in 1: redirect; discard everything buffered and the beat offered this cycle.

## Operation
- `in_fire = IFU_o_valid & IFU_i_ready`. `out_fire = IDU_i_commit & ~IDU_stall`.
- There are two storage entries:
  - OUT drives the `IDU_i_*` outputs.
  - SKID holds the overflow beat.
- The state machine tracks occupancy: EMPTY, ONE (OUT valid), TWO (OUT and SKID valid).
- EMPTY: `in_fire` → ONE, OUT ← in.
- ONE:
  - `in_fire & out_fire` → ONE, OUT ← in.
  - `in_fire & ~out_fire` → TWO, SKID ← in.
  - `~in_fire & out_fire` → EMPTY.
  - otherwise hold.
- TWO: `out_fire` → ONE, OUT ← SKID. Otherwise hold. `in_fire` is impossible because ready is low.
- `IFU_i_ready = (state != TWO)`. It comes from a flop and has no combinational path from `IDU_stall` or `EXU_o_flush`.
- `IDU_i_commit = (state != EMPTY)`.
- When EMPTY, `IDU_i_pc = RESET_PC` and `IDU_i_inst = NOP_INST`. These are explicit muxed/reset values; stale data is never shown.
- Flush has priority over every other event in the same cycle:
  - next state is EMPTY;
  - the `in_fire` beat of that cycle is dropped;
  - OUT/SKID data registers load NOP/RESET_PC.
- Ordering is strict FIFO: SKID content always follows OUT content.
- No beat is duplicated or lost except by flush.

## Timing
- Reset (async assert): state EMPTY, `IFU_i_ready=1`, `IDU_i_commit=0`, `IDU_i_pc=RESET_PC`, `IDU_i_inst=NOP_INST`. Release is synchronous to the next edge.
- Latency: an `in_fire` at edge N appears on the `IDU_i_*` outputs after edge N (1 cycle).
- Throughput: 1 beat/cycle with no stall.
- Stall asserted while in ONE with fetch streaming:
  - one more beat is accepted into SKID;
  - `IFU_i_ready` drops the cycle after that beat is captured.
- Stall released while in TWO: `IFU_i_ready` returns high one cycle after the `out_fire`.
- Flush is effective at the next edge. The cycle after a flush shows `IDU_i_commit=0` and `IFU_i_ready=1`.
- Flush and stall together: flush wins.
- Reset asserted mid-transfer: everything is cleared immediately, asynchronously.

## Structure
- Shared package `ifid_pkg`:
  - state enum `ifid_state_t` {EMPTY, ONE, TWO}.
  - struct `ifid_beat_t` {pc[31:0], inst[31:0]}.
  - constants `IFID_NOP_INST` and `IFID_RESET_PC` (defaults for the parameters).
- One sub-module is natural: `ifid_beat_reg`, a data register with async reset, load enable, and clear-to-NOP. It is instantiated twice (OUT, SKID).
- Occupancy FSM and handshake logic live in the top.

## Test plan
- Reset then idle → `IDU_i_commit=0`, `IDU_i_pc=32'h8000_0000`, `IDU_i_inst=32'h00000013`, `IFU_i_ready=1`.
- Stream pc 0x80000000, 0x80000004, 0x80000008 with no stall → each appears exactly one cycle after its `in_fire`, in order, `IDU_i_commit` high continuously.
- Stall for 3 cycles while streaming:
  - beat A is held on the outputs;
  - beat B is captured in SKID;
  - `IFU_i_ready=0` from the next cycle;
  - after release, A, B, C are consumed in order with no gap or duplicate.
- Flush while in TWO (A presented, B in SKID, C offered) → next cycle EMPTY, NOP on outputs, `IFU_i_ready=1`; none of A, B, C is ever consumed.
- Flush with `IDU_stall=1` in the same cycle → flush wins, state EMPTY next cycle.
- Async `rst` pulse mid-cycle while in TWO → outputs go to reset values immediately, without waiting for a clock edge; normal streaming resumes after release.
